// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, port
// encodings and the tie-break helper used by the two-port arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } arb_state_t;

   localparam logic PORT_CORE   = 1'b0;
   localparam logic PORT_LOADER = 1'b1;

   // Winner when both ports request in the same cycle.
   function automatic logic tie_winner(input logic last_owner, input logic fixed_prio);
      if (fixed_prio) begin
         return PORT_LOADER;
      end else begin
         return ~last_owner;
      end
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Combinational two-port arbiter: round-robin on ties, or loader-wins
// when fixed priority is selected.
module rr_arbiter2
   import dmem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_owner,
   input  logic fixed_prio,
   output logic winner,
   output logic any_req
);

   // Select the winning port from the current requests.
   always_comb begin
      winner  = PORT_CORE;
      any_req = req0 | req1;
      if (req0 && req1) begin
         winner = tie_winner(last_owner, fixed_prio);
      end else if (req1) begin
         winner = PORT_LOADER;
      end else begin
         winner = PORT_CORE;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares a single-port memory between the core
// load/store path (port 0) and the loader/debug path (port 1). One access
// is sequenced every four cycles; busy lets the core stall its PC.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int FIXED_PRIO = 0
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic FIXED_PRIO_B = (FIXED_PRIO != 0);

   arb_state_t        state_r;
   logic              owner_r;
   logic              last_owner_r;
   logic              we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic [DATA_W-1:0] rdata0_r;
   logic [DATA_W-1:0] rdata1_r;
   logic              rvalid0_r;
   logic              rvalid1_r;
   logic              mem_en_r;
   logic              mem_we_r;

   logic              winner_s;
   logic              any_req_s;
   logic              gnt0_s;
   logic              gnt1_s;

   rr_arbiter2 u_rr_arbiter2 (
      .req0       (req0),
      .req1       (req1),
      .last_owner (last_owner_r),
      .fixed_prio (FIXED_PRIO_B),
      .winner     (winner_s),
      .any_req    (any_req_s)
   );

   // Grants are only issued from IDLE and are suppressed while reset is held.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (reset && (state_r == IDLE) && any_req_s) begin
         gnt0_s = (winner_s == PORT_CORE);
         gnt1_s = (winner_s == PORT_LOADER);
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Access sequencer: latch the winner, strobe memory, capture, respond.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r      <= IDLE;
         owner_r      <= PORT_CORE;
         last_owner_r <= PORT_LOADER;
         we_r         <= 1'b0;
         addr_r       <= {ADDR_W{1'b0}};
         wdata_r      <= {DATA_W{1'b0}};
         rdata0_r     <= {DATA_W{1'b0}};
         rdata1_r     <= {DATA_W{1'b0}};
         rvalid0_r    <= 1'b0;
         rvalid1_r    <= 1'b0;
         mem_en_r     <= 1'b0;
         mem_we_r     <= 1'b0;
      end else begin
         mem_en_r  <= 1'b0;
         mem_we_r  <= 1'b0;
         rvalid0_r <= 1'b0;
         rvalid1_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  owner_r      <= winner_s;
                  last_owner_r <= winner_s;
                  if (winner_s == PORT_LOADER) begin
                     we_r     <= we1;
                     addr_r   <= addr1;
                     wdata_r  <= wdata1;
                     mem_we_r <= we1;
                  end else begin
                     we_r     <= we0;
                     addr_r   <= addr0;
                     wdata_r  <= wdata0;
                     mem_we_r <= we0;
                  end
                  mem_en_r <= 1'b1;
                  state_r  <= ISSUE;
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               state_r <= CAPTURE;
            end
            CAPTURE: begin
               if (!we_r) begin
                  if (owner_r == PORT_LOADER) begin
                     rdata1_r <= mem_rdata;
                  end else begin
                     rdata0_r <= mem_rdata;
                  end
               end
               rvalid0_r <= (owner_r == PORT_CORE);
               rvalid1_r <= (owner_r == PORT_LOADER);
               state_r   <= RESP;
            end
            RESP: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign gnt0      = gnt0_s;
   assign gnt1      = gnt1_s;
   assign rvalid0   = rvalid0_r;
   assign rvalid1   = rvalid1_r;
   assign rdata0    = rdata0_r;
   assign rdata1    = rdata1_r;
   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;
   assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a scoreboard queue of expected
// accesses is filled on every grant and drained on every response.
module tb_dmem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0, we0, req1, we1;
   logic [9:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy;
   logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
   logic [9:0]  mem_addr;

   logic        f_req0, f_we0, f_req1, f_we1;
   logic [9:0]  f_addr0, f_addr1;
   logic [31:0] f_wdata0, f_wdata1;
   logic        f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_mem_en, f_mem_we, f_busy;
   logic [31:0] f_rdata0, f_rdata1, f_mem_wdata, f_mem_rdata;
   logic [9:0]  f_mem_addr;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   typedef struct {
      logic        port;
      logic        we;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          issue;
      int          due;
   } txn_t;

   txn_t        sb_q[$];
   int          gnt_port_log[$];
   int          gnt_cyc_log[$];
   logic [31:0] mem0    [0:1023];
   logic [31:0] exp_mem [0:1023];
   logic [31:0] rdata_exp0 = 32'h0;
   logic [31:0] rdata_exp1 = 32'h0;

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(0)) u_dut (
      .clock(clock), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(1)) u_dut_fp (
      .clock(clock), .reset(reset),
      .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0),
      .gnt0(f_gnt0), .rvalid0(f_rvalid0), .rdata0(f_rdata0),
      .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1),
      .gnt1(f_gnt1), .rvalid1(f_rvalid1), .rdata1(f_rdata1),
      .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr),
      .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata), .busy(f_busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end else begin
         n_pass++;
      end
   endtask

   // Synchronous-read memory model for the round-robin instance.
   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem0[i]    = 32'hA5000000 | 32'(i);
         exp_mem[i] = 32'hA5000000 | 32'(i);
      end
      mem0[5]    = 32'hDEADBEEF;
      exp_mem[5] = 32'hDEADBEEF;
      forever begin
         @(posedge clock);
         if (mem_en) begin
            mem_rdata <= mem0[mem_addr];
            if (mem_we) mem0[mem_addr] = mem_wdata;
         end
      end
   end

   // Memory model for the fixed-priority instance: data is a function of address.
   always @(posedge clock) begin
      if (f_mem_en) f_mem_rdata <= {22'h0, f_mem_addr} ^ 32'hCAFE0000;
   end

   // Scoreboard monitor for the round-robin instance.
   initial begin
      txn_t t;
      logic exp_en, exp_rv;
      forever begin
         @(negedge clock);
         check_eq("busy", busy, 32'(sb_q.size() != 0));
         exp_en = 1'b0;
         exp_rv = 1'b0;
         if (sb_q.size() != 0) begin
            exp_en = (sb_q[0].issue == cyc);
            exp_rv = (sb_q[0].due == cyc);
         end
         check_eq("mem_en", mem_en, 32'(exp_en));
         if (exp_en) begin
            check_eq("mem_we", mem_we, 32'(sb_q[0].we));
            check_eq("mem_addr", mem_addr, 32'(sb_q[0].addr));
            if (sb_q[0].we) check_eq("mem_wdata", mem_wdata, sb_q[0].wdata);
         end else begin
            check_eq("mem_we_idle", mem_we, 32'h0);
         end
         if (exp_rv) begin
            t = sb_q.pop_front();
            check_eq("rvalid0", rvalid0, 32'(t.port == 1'b0));
            check_eq("rvalid1", rvalid1, 32'(t.port == 1'b1));
            check_eq("rdata", t.port ? rdata1 : rdata0, t.exp_rdata);
         end else begin
            check_eq("rvalid_none", {rvalid1, rvalid0}, 32'h0);
         end
         if (!reset) begin
            check_eq("gnt_in_reset", {gnt1, gnt0}, 32'h0);
            sb_q.delete();
            rdata_exp0 = 32'h0;
            rdata_exp1 = 32'h0;
         end else if (gnt0 || gnt1) begin
            check_eq("gnt_onehot", {gnt1, gnt0} == 2'b11, 32'h0);
            t.port  = gnt1;
            t.we    = gnt1 ? we1 : we0;
            t.addr  = gnt1 ? addr1 : addr0;
            t.wdata = gnt1 ? wdata1 : wdata0;
            if (!t.we) begin
               t.exp_rdata = exp_mem[t.addr];
               if (t.port) rdata_exp1 = t.exp_rdata;
               else        rdata_exp0 = t.exp_rdata;
            end else begin
               exp_mem[t.addr] = t.wdata;
               t.exp_rdata = t.port ? rdata_exp1 : rdata_exp0;
            end
            t.issue = cyc + 1;
            t.due   = cyc + 3;
            sb_q.push_back(t);
            gnt_port_log.push_back(int'(t.port));
            gnt_cyc_log.push_back(cyc);
         end
      end
   end

   task automatic do_access(input logic port, input logic we, input logic [9:0] addr,
                            input logic [31:0] wd);
      logic got;
      if (port) begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
      end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         got = port ? gnt1 : gnt0;
      end
      check_eq("gnt_wait", got, 32'h1);
      @(posedge clock); #1;
      req0 = 1'b0; req1 = 1'b0;
      repeat (3) @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int  n0, n1, nrv0, nrv1;
      logic got;
      reset = 1'b0;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = 10'h010; addr1 = 10'h011; wdata0 = 32'h0; wdata1 = 32'h0;
      f_req0 = 1'b0; f_req1 = 1'b0; f_we0 = 1'b0; f_we1 = 1'b0;
      f_addr0 = 10'h0; f_addr1 = 10'h0; f_wdata0 = 32'h0; f_wdata1 = 32'h0;

      // Reset held with both requests high, then first tie goes to port 0.
      repeat (2) begin
         @(negedge clock);
         check_eq("t1_rst_outs", {gnt0, gnt1, mem_en, rvalid0, rvalid1, busy}, 32'h0);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      check_eq("t1_gnt0", gnt0, 32'h1);
      check_eq("t1_gnt1", gnt1, 32'h0);
      @(posedge clock); #1;
      req0 = 1'b0; req1 = 1'b0;
      repeat (3) @(posedge clock);
      #1;

      // Port 0 read.
      do_access(1'b0, 1'b0, 10'h005, 32'h0);
      check_eq("t2_rdata0", rdata0, 32'hDEADBEEF);

      // Port 1 read, write (rdata1 unchanged), read back.
      do_access(1'b1, 1'b0, 10'h3FF, 32'h0);
      do_access(1'b1, 1'b1, 10'h3FF, 32'h12345678);
      check_eq("t3_rdata1_hold", rdata1, 32'hA50003FF);
      do_access(1'b1, 1'b0, 10'h3FF, 32'h0);
      check_eq("t3_readback", rdata1, 32'h12345678);

      // Round-robin with both requests held.
      gnt_port_log.delete();
      gnt_cyc_log.delete();
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = 10'h020; addr1 = 10'h021;
      repeat (13) @(posedge clock);
      #1;
      req0 = 1'b0; req1 = 1'b0;
      check_eq("t4_ngnt", gnt_port_log.size(), 32'd4);
      for (int i = 0; i < gnt_port_log.size() && i < 4; i++) begin
         check_eq("t4_order", gnt_port_log[i], 32'(i % 2));
         if (i > 0) check_eq("t4_spacing", gnt_cyc_log[i] - gnt_cyc_log[i-1], 32'd4);
      end
      repeat (4) @(posedge clock);
      #1;

      // Fixed priority: port 1 wins every IDLE until it drops.
      f_req0 = 1'b1; f_req1 = 1'b1; f_addr0 = 10'h040; f_addr1 = 10'h041;
      n0 = 0; n1 = 0; nrv0 = 0; nrv1 = 0;
      for (int i = 0; i < 13; i++) begin
         @(negedge clock);
         n0 += int'(f_gnt0);
         n1 += int'(f_gnt1);
         nrv0 += int'(f_rvalid0);
         nrv1 += int'(f_rvalid1);
      end
      check_eq("t5_n_gnt1", n1, 32'd4);
      check_eq("t5_n_gnt0", n0, 32'd0);
      check_eq("t5_n_rvalid1", nrv1, 32'd3);
      check_eq("t5_n_rvalid0", nrv0, 32'd0);
      @(posedge clock); #1;
      f_req1 = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clock);
         got = f_gnt0;
      end
      check_eq("t5_gnt0_after", got, 32'h1);
      check_eq("t5_gnt1_after", f_gnt1, 32'h0);
      @(posedge clock); #1;
      f_req0 = 1'b0;
      repeat (3) @(negedge clock);
      check_eq("t5_rvalid0", f_rvalid0, 32'h1);
      check_eq("t5_rdata0", f_rdata0, 32'hCAFE0040);
      repeat (2) @(posedge clock);
      #1;

      // Reset during CAPTURE abandons the read.
      req0 = 1'b1; we0 = 1'b0; addr0 = 10'h007;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         got = gnt0;
      end
      check_eq("t6_gnt0", got, 32'h1);
      @(posedge clock); #1;
      req0 = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check_eq("t6_busy_capture", busy, 32'h1);
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      check_eq("t6_busy_idle", busy, 32'h0);
      check_eq("t6_rdata0_clr", rdata0, 32'h0);
      check_eq("t6_rvalid0", rvalid0, 32'h0);
      repeat (4) @(posedge clock);
      #1;
      check_eq("t6_no_late_rdata", rdata0, 32'h0);
      do_access(1'b0, 1'b0, 10'h005, 32'h0);
      check_eq("t6_after_rdata0", rdata0, 32'hDEADBEEF);
      repeat (2) @(posedge clock);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
